// File: rtl/mac_pkg.sv
// Shared sizing defaults and constant helpers for the MAC array datapath.
package mac_pkg;

    localparam int BW_DEF      = 4;
    localparam int PSUM_BW_DEF = 16;
    localparam int LANES_DEF   = 4;

    // Full-precision adder tree width: signed product plus one bit per tree level.
    function automatic int tree_width(input int bw, input int lanes);
        return 2 * bw + 1 + $clog2(lanes);
    endfunction

    function automatic longint smax(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint smin(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/mac_tree.sv
// Per-lane product registers (S1) followed by a full-precision adder tree
// registered once at its output (S2).
module mac_tree
    import mac_pkg::*;
#(
    parameter int bw    = BW_DEF,
    parameter int lanes = LANES_DEF,
    localparam int TW   = tree_width(bw, lanes)
) (
    input  logic                   clk,
    input  logic [lanes*bw-1:0]    x_in,
    input  logic [lanes*bw-1:0]    w_in,
    output logic signed [TW-1:0]   tree_p2
);

    localparam int PW = 2 * bw + 1;

    logic signed [PW-1:0] prod_p1 [lanes];
    logic signed [TW-1:0] node [1:2*lanes-1];

    // Activation is unsigned, so it gains a zero sign bit before the signed multiply.
    function automatic logic signed [PW-1:0] lane_mult(input logic [bw-1:0] x,
                                                       input logic signed [bw-1:0] w);
        logic signed [PW-1:0] xs;
        logic signed [PW-1:0] ws;
        xs = PW'($signed({1'b0, x}));
        ws = PW'(w);
        return xs * ws;
    endfunction

    // ---- S1: lane products ----
    always_ff @(posedge clk) begin
        for (int k = 0; k < lanes; k++) begin
            prod_p1[k] <= lane_mult(x_in[k*bw +: bw], $signed(w_in[k*bw +: bw]));
        end
    end

    // Heap-ordered tree: leaves at lanes..2*lanes-1, root at index 1.
    always_comb begin
        for (int k = 0; k < lanes; k++) begin
            node[lanes + k] = TW'(prod_p1[k]);
        end
        for (int i = lanes - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i + 1];
        end
    end

    // ---- S2: tree sum ----
    always_ff @(posedge clk) begin
        tree_p2 <= node[1];
    end

endmodule

// File: rtl/mac_array_acc.sv
// Pipelined dot-product engine with group accumulation onto an incoming
// partial sum; optional saturation and a per-group sticky overflow flag.
module mac_array_acc
    import mac_pkg::*;
#(
    parameter int bw      = BW_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int lanes   = LANES_DEF,
    parameter int sat     = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [lanes*bw-1:0]        x_in,
    input  logic [lanes*bw-1:0]        w_in,
    input  logic signed [psum_bw-1:0]  psum_in,
    output logic                       out_valid,
    output logic signed [psum_bw-1:0]  out,
    output logic                       ovf
);

    localparam int TW = tree_width(bw, lanes);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic signed [psum_bw-1:0] PSUM_MAX = psum_bw'(smax(psum_bw));
    localparam logic signed [psum_bw-1:0] PSUM_MIN = psum_bw'(smin(psum_bw));

    logic [0:0]                  state;
    logic                        first;
    logic                        vld_p1, first_p1, last_p1;
    logic signed [psum_bw-1:0]   psum_p1;
    logic                        vld_p2, first_p2, last_p2;
    logic signed [psum_bw-1:0]   psum_p2;
    logic signed [TW-1:0]        tree_p2;
    logic                        vld_p3, last_p3, ovf_p3;
    logic signed [psum_bw-1:0]   acc_p3;
    logic signed [psum_bw-1:0]   base;
    logic signed [psum_bw:0]     sum_ext;
    logic                        ovf_now;

    // Sign-extends or truncates the tree result; truncation is not flagged.
    function automatic logic signed [psum_bw-1:0] fit_tree(input logic signed [TW-1:0] t);
        return psum_bw'(t);
    endfunction

    function automatic logic signed [psum_bw-1:0] sat_acc(input logic signed [psum_bw:0] s);
        if (sat != 0 && (s[psum_bw] != s[psum_bw-1])) begin
            return s[psum_bw] ? PSUM_MIN : PSUM_MAX;
        end
        return s[psum_bw-1:0];
    endfunction

    assign first = (state == IDLE);

    mac_tree #(.bw(bw), .lanes(lanes)) u_tree (
        .clk     (clk),
        .x_in    (x_in),
        .w_in    (w_in),
        .tree_p2 (tree_p2)
    );

    // ---- S1/S2: sideband travelling with the product and tree stages ----
    always_ff @(posedge clk) begin
        first_p1 <= first;
        last_p1  <= in_last;
        psum_p1  <= psum_in;
        first_p2 <= first_p1;
        last_p2  <= last_p1;
        psum_p2  <= psum_p1;
        last_p3  <= last_p2;
    end

    always_comb begin
        base    = first_p2 ? psum_p2 : acc_p3;
        sum_ext = (psum_bw+1)'(base) + (psum_bw+1)'(fit_tree(tree_p2));
        ovf_now = sum_ext[psum_bw] ^ sum_ext[psum_bw-1];
    end

    // ---- S3: accumulator, then output register ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            acc_p3    <= '0;
            ovf_p3    <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (in_valid) begin
                state <= in_last ? IDLE : ACCUM;
            end
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                acc_p3 <= sat_acc(sum_ext);
                ovf_p3 <= first_p2 ? ovf_now : (ovf_p3 | ovf_now);
            end
            out_valid <= vld_p3 && last_p3;
            if (vld_p3 && last_p3) begin
                out <= acc_p3;
                ovf <= ovf_p3;
            end
        end
    end

endmodule

// File: doc/mac_array_acc.md
# mac_array_acc

Parametrised, pipelined dot-product engine: `lanes` parallel multiplies, a registered adder tree and a group accumulator that sums any number of consecutive input vectors onto an incoming partial sum. It is the next-generation replacement for the fixed 4-lane combinational MAC wrapper inside the PE/accumulation path. It adds pipelining, valid signalling, multi-vector accumulation, optional saturation and an overflow flag.

## Interface
- `bw`, 4: activation and weight element width.
- `psum_bw`, 16: partial-sum and output width.
- `lanes`, 4: parallel multiply lanes. Must be a power of two, at least 2.
- `sat`, 0: 1 saturates the accumulator at signed `psum_bw` limits. 0 wraps modulo 2^psum_bw.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: input vector present this cycle.
- `in_last` in 1: this vector closes the current group. Qualified by `in_valid`.
- `x_in` in lanes*bw: unsigned activations. Lane k is bits [k*bw +: bw].
- `w_in` in lanes*bw: signed two's-complement weights, same lane packing.
- `psum_in` in psum_bw: signed initial partial sum. Sampled only with the first vector of a group.
- `out_valid` out 1: one-cycle pulse when a group result is on `out`.
- `out` out psum_bw: signed group result. Holds its value until the next result.
- `ovf` out 1: overflow/saturation occurred in the group just reported. Valid with `out_valid`.

## Operation
- Group tracking uses a 1-bit state, IDLE/ACCUM.
  - IDLE: the next valid vector is a group's first vector, and `psum_in` is captured with it.
  - Valid with `in_last`=1 goes to IDLE, or stays there. A single-vector group, first and last in the same beat, is legal.
  - Valid with `in_last`=0 goes to ACCUM.
  - In ACCUM, `psum_in` is ignored.
  - `in_valid`=0 cycles are allowed anywhere and change nothing.
- Stage S1 registers per-lane products. Each x is zero-extended to bw+1 bits, then multiplied signed, giving a signed 2*bw+1 bit product. S1 also registers valid, first, last and the captured psum.
- Stage S2 is the adder tree, registered once at its output.
  - Each level grows by 1 bit. The final width is 2*bw+1+log2(lanes).
  - The result is sign-extended to psum_bw; if narrower, it is truncated. Truncation is not an overflow.
  - S2 registers the same sideband as S1.
- Stage S3 is the accumulator.
  - Base is `psum` if first, otherwise the accumulator register.
  - Update: acc ← base + tree, computed at psum_bw+1 bits.
  - Overflow means the signed result leaves the psum_bw range.
    - sat=1: clamp to 2^(psum_bw-1)-1 or -2^(psum_bw-1).
    - sat=0: keep the low psum_bw bits.
  - The sticky `ovf` flag clears on a group's first beat (that beat's own overflow still counts) and sets on any overflow.
- Output: a last beat in S3 loads `out` with the new acc value, pulses `out_valid` and presents the group's `ovf`.
- There is no backpressure: a new vector may be accepted every cycle, including the cycle after `in_last`.
- Reset (`reset_n`=0 at an edge):
  - state goes to IDLE and all stage valids to 0;
  - acc, `out` and `ovf` go to 0; `out_valid` goes to 0.
  - A partial group in flight is discarded and never reported.

## Timing
- Latency: the last vector is sampled at edge E. `out_valid`=1 and `out` is valid in the cycle after edge E+3, i.e. after three more edges.
- Throughput is one vector per cycle. Back-to-back groups have no bubble.
- `out_valid` is high for exactly one cycle per group.
- All outputs are registered. There is no combinational input-to-output path.
- Reset values: `out_valid`=0, `out`=0, `ovf`=0.

## Structure
- Shared package `mac_pkg` holds:
  - defaults for bw, psum_bw and lanes;
  - the function for tree width, 2*bw+1+$clog2(lanes);
  - signed min/max constant functions for the saturation limits.
- One sub-module, `mac_tree`: the S1 product registers plus the S2 registered adder tree, parametrised by bw and lanes. `mac_array_acc` holds the group state, sideband pipeline and accumulator.

## Test plan
All cases use lanes=4, bw=4, psum_bw=16.
- Single-vector group: x={1,2,3,4}, w={1,1,1,1}, psum_in=10, last=1 → out=20 with a one-cycle `out_valid`, 4 cycles after input; `ovf`=0.
- Negative weights: x=all 15, w=all -8, psum_in=0, last=1 → out=0xFE20 (-480).
- Back-to-back groups:
  - Group A: 3 vectors of x=1s, w=2s, psum_in=5 → out=29.
  - Group B follows in the next cycle: one vector of x=1s, w=3s, psum_in=0 → out=12.
  - The two `out_valid` pulses are 1 cycle apart.
- Bubbles inside a group: group A from the back-to-back case, with `in_valid`=0 for 2 cycles between vectors → out=29. The `psum_in`=999 driven during ACCUM is ignored.
- Overflow: psum_in=32760, x=all 15, w=all 7 (sum 420).
  - sat=1 → out=32767, ovf=1.
  - sat=0 → out=0x819C, ovf=1.
  - The next group without overflow reports ovf=0.
- Reset mid-group: 2 non-last vectors, then `reset_n`=0 for 1 cycle → no `out_valid`, `out`=0. A following single-vector group (test 1 values) → out=20.
